// File: rtl/lsu_pkg.sv
// Shared load/store types: access size, LSU FSM state, latched request and
// the lane byte-enable helper used by the data and instruction-fetch paths.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic      write;
        lsu_size_e size;
        logic [1:0] a;
        logic      uns;
    } lsu_req_t;

    localparam logic [1:0] LSU_SIZE_ILLEGAL = 2'd3;

    // Misaligned halves/words are folded onto their natural lanes.
    function automatic logic [3:0] byteena_for(lsu_size_e size, logic [1:0] a);
        case (size)
            LSU_BYTE: byteena_for = 4'b0001 << a;
            LSU_HALF: byteena_for = a[1] ? 4'b1100 : 4'b0011;
            default:  byteena_for = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Request/response handshake plus word-addressed data bus between the core
// memory stage, the LSU, and the mmio/data RAM side.
interface lsu_bus_master_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] bus_address;
    logic [3:0]        bus_byteena;
    logic              bus_clken;
    logic [31:0]       bus_data;
    logic              bus_wren;
    logic [31:0]       bus_q;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, bus_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output bus_address, bus_byteena, bus_clken, bus_data, bus_wren
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, bus_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  bus_address, bus_byteena, bus_clken, bus_data, bus_wren
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data and
// load shift + sign/zero extension. Also reused by the instruction-fetch path.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic [1:0]  i_a,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byteena,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shifted;
    logic        w_sext;

    always_comb begin
        o_byteena = byteena_for(i_size, i_a);
        w_sext    = ~i_unsigned;
        case (i_size)
            LSU_BYTE: begin
                o_wdata   = {4{i_wdata[7:0]}};
                w_shifted = i_rdata >> {i_a, 3'b000};
            end
            LSU_HALF: begin
                o_wdata   = {2{i_wdata[15:0]}};
                w_shifted = i_rdata >> {i_a[1], 4'b0000};
            end
            default: begin
                o_wdata   = i_wdata;
                w_shifted = i_rdata;
            end
        endcase
        // Word loads ignore the unsigned flag: nothing to extend.
        case (i_size)
            LSU_BYTE: o_rdata = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
            LSU_HALF: o_rdata = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
            default:  o_rdata = w_shifted;
        endcase
    end
endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store bus initiator (IDLE->ISSUE->WAIT->RESP).
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int READ_LATENCY = 1
) (
    input logic              clock,
    input logic              reset_n,
    lsu_bus_master_if.master bus
);
    lsu_state_e        r_state;
    lsu_req_t          r_req;
    logic [2:0]        r_cnt;
    logic              r_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_byteena;
    logic              r_clken;
    logic [31:0]       r_data;
    logic              r_wren;

    logic              w_idle;
    logic              w_err;
    lsu_size_e         w_size;
    logic [1:0]        w_a;
    logic [3:0]        w_byteena;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic              w_unused_addr;

    assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

    // Store lanes come from the live request at accept; load extraction
    // from the latched request while waiting on bus_q.
    assign w_idle = (r_state == ST_IDLE);
    assign w_size = w_idle ? lsu_size_e'(bus.req_size) : r_req.size;
    assign w_a    = w_idle ? bus.req_addr[1:0] : r_req.a;

    lsu_lane_align u_align (
        .i_size     (w_size),
        .i_a        (w_a),
        .i_unsigned (r_req.uns),
        .i_wdata    (bus.req_wdata),
        .i_rdata    (bus.bus_q),
        .o_byteena  (w_byteena),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    always_comb begin
        w_err = (bus.req_size == LSU_SIZE_ILLEGAL);
`ifdef LSU_MISALIGN_TRAP_EN
        if (bus.req_size == LSU_HALF && bus.req_addr[0])
            w_err = 1'b1;
        if (bus.req_size == LSU_WORD && bus.req_addr[1:0] != 2'b00)
            w_err = 1'b1;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_addr       <= '0;
            r_byteena    <= '0;
            r_clken      <= 1'b0;
            r_data       <= '0;
            r_wren       <= 1'b0;
        end else begin
            r_clken      <= 1'b0;
            r_wren       <= 1'b0;
            r_byteena    <= '0;
            r_data       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (bus.req_valid && r_ready) begin
                        r_ready     <= 1'b0;
                        r_req.write <= bus.req_write;
                        r_req.size  <= lsu_size_e'(bus.req_size);
                        r_req.a     <= bus.req_addr[1:0];
                        r_req.uns   <= bus.req_unsigned;
                        if (w_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state   <= ST_ISSUE;
                            r_clken   <= 1'b1;
                            r_wren    <= bus.req_write;
                            r_byteena <= w_byteena;
                            r_data    <= w_wdata;
                            r_addr    <= bus.req_addr[ADDR_W+1:2];
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_req.write) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 3'(READ_LATENCY);
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    // bus_q is valid READ_LATENCY cycles after ISSUE.
                    if (r_cnt == 3'd1) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_rdata;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_err    = r_resp_err;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.bus_address = r_addr;
    assign bus.bus_byteena = r_byteena;
    assign bus.bus_clken   = r_clken;
    assign bus.bus_data    = r_data;
    assign bus.bus_wren    = r_wren;
endmodule
